// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types, bus-cycle constants and helpers for the RAM bus
//             arbiter (CPU vs. secondary master on the 32-bit RAM port).
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

    // Arbiter sequencing states; explicit 4-bit encoding
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CPU_ACT  = 4'd1,
        CPU_WAIT = 4'd2,
        CPU_TERM = 4'd3,
        CPU_END  = 4'd4,
        DMA_ACT  = 4'd5,
        DMA_WAIT = 4'd6,
        DMA_TERM = 4'd7,
        DMA_END  = 4'd8
    } arbState_t;

    // Which master received the most recent grant (round-robin tie break)
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    // 68030 SIZ1:SIZ0 transfer sizes
    localparam logic [1:0] SIZ_LONG  = 2'b00;
    localparam logic [1:0] SIZ_BYTE  = 2'b01;
    localparam logic [1:0] SIZ_WORD  = 2'b10;
    localparam logic [1:0] SIZ_3BYTE = 2'b11;

    // FC1:FC0 codes that denote ordinary data/program accesses; 00 and 11
    // (CPU space / interrupt acknowledge) never touch RAM
    localparam logic [1:0] FC_DATA = 2'b01;
    localparam logic [1:0] FC_PROG = 2'b10;

    // Number of bytes moved by a transfer of the given SIZ encoding
    function automatic logic [2:0] bytesFromSiz(input logic [1:0] s);
        logic [2:0] n;
        case (s)
            SIZ_LONG:  n = 3'd4;
            SIZ_BYTE:  n = 3'd1;
            SIZ_WORD:  n = 3'd2;
            SIZ_3BYTE: n = 3'd3;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_lane_decode.sv
`default_nettype none
// ============================================================================
//  Module   : ram_lane_decode
//  Purpose  : Combinational byte-lane enable decode for CPU accesses to the
//             32-bit RAM port. Reads enable all lanes; writes enable the
//             lanes covered by A1:A0 and the transfer size, clipped at lane 3.
//             laneEn[3] corresponds to D31:24 (lane 0).
//  Revision : 1.0  initial release
// ============================================================================
module ram_lane_decode
    import mem_pkg::*;
(
    input  logic [1:0] addrLow,
    input  logic [1:0] siz,
    input  logic       RnW,
    output logic [3:0] laneEn
);

    logic [3:0] first_lane;
    logic [3:0] end_lane;

    assign first_lane = {2'b00, addrLow};
    assign end_lane   = first_lane + {1'b0, bytesFromSiz(siz)};

    // Enable lane k when it lies in [first_lane, end_lane); reads take all lanes
    always_comb begin
        laneEn = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (RnW || ((4'(k) >= first_lane) && (4'(k) < end_lane))) begin
                laneEn[2'(3 - k)] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_bus_arbiter
//  Purpose  : Shares the 32-bit RAM between the CPU and one secondary master.
//             Round-robin arbitration in IDLE, byte-lane chip enables,
//             read/write strobes, programmable wait states, 32-bit DSACK
//             termination for the CPU and a one-clock ack for the secondary.
//             Every output is a flop.
//  Revision : 1.0  initial release
// ============================================================================
module ram_bus_arbiter
    import mem_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic       sysClk,
    input  logic       sysReset,
    input  logic       nAS,
    input  logic       addr31,
    input  logic [1:0] addrLow,
    input  logic [1:0] siz,
    input  logic       RnW,
    input  logic [1:0] cpuFC,
    input  logic       dmaReq,
    input  logic       dmaRnW,
    input  logic [3:0] dmaBe,
    output logic       dmaGnt,
    output logic       dmaAck,
    output logic       ramAddrSel,
    output logic [3:0] nRamCE,
    output logic       nMemRd,
    output logic       nMemWr,
    output logic [1:0] nDsack
);

    // Legal range is 0..7, so the counter is three bits wide
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    arbState_t  state;
    arbState_t  state_next;
    owner_t     last_grant;
    owner_t     last_grant_next;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_next;

    logic       cpu_req;
    logic [3:0] lane_en;

    logic [3:0] ce_next;
    logic       rd_next;
    logic       wr_next;
    logic [1:0] dsack_next;
    logic       gnt_next;
    logic       ack_next;
    logic       sel_next;

    // Only user/supervisor data and program cycles below A31 are RAM cycles
    assign cpu_req = !nAS && !addr31 && ((cpuFC == FC_DATA) || (cpuFC == FC_PROG));

    ram_lane_decode u_lane_decode (
        .addrLow (addrLow),
        .siz     (siz),
        .RnW     (RnW),
        .laneEn  (lane_en)
    );

    // State, wait counter, grant history and all output flops
    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state      <= IDLE;
            last_grant <= OWN_DMA;
            wait_cnt   <= 3'd0;
            nRamCE     <= 4'hF;
            nMemRd     <= 1'b1;
            nMemWr     <= 1'b1;
            nDsack     <= 2'b11;
            dmaGnt     <= 1'b0;
            dmaAck     <= 1'b0;
            ramAddrSel <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            wait_cnt   <= wait_cnt_next;
            nRamCE     <= ce_next;
            nMemRd     <= rd_next;
            nMemWr     <= wr_next;
            nDsack     <= dsack_next;
            dmaGnt     <= gnt_next;
            dmaAck     <= ack_next;
            ramAddrSel <= sel_next;
        end
    end

    // Next-state: arbitration in IDLE, wait sequencing, CPU abort on nAS high
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        wait_cnt_next   = wait_cnt;
        case (state)
            IDLE: begin
                if (cpu_req && (!dmaReq || (last_grant == OWN_DMA))) begin
                    state_next      = CPU_ACT;
                    last_grant_next = OWN_CPU;
                end else if (dmaReq) begin
                    state_next      = DMA_ACT;
                    last_grant_next = OWN_DMA;
                end
            end
            CPU_ACT: begin
                if (nAS) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = WAIT_LOAD;
                    state_next    = (WAIT_LOAD == 3'd0) ? CPU_TERM : CPU_WAIT;
                end
            end
            CPU_WAIT: begin
                if (nAS) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt - 3'd1;
                    if (wait_cnt <= 3'd1) begin
                        state_next = CPU_TERM;
                    end
                end
            end
            CPU_TERM: begin
                state_next = nAS ? IDLE : CPU_END;
            end
            CPU_END: begin
                if (nAS) begin
                    state_next = IDLE;
                end
            end
            DMA_ACT: begin
                wait_cnt_next = WAIT_LOAD;
                state_next    = (WAIT_LOAD == 3'd0) ? DMA_TERM : DMA_WAIT;
            end
            DMA_WAIT: begin
                wait_cnt_next = wait_cnt - 3'd1;
                if (wait_cnt <= 3'd1) begin
                    state_next = DMA_TERM;
                end
            end
            DMA_TERM: begin
                state_next = DMA_END;
            end
            DMA_END: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output values to be registered, chosen by the state being entered
    always_comb begin
        ce_next    = nRamCE;
        rd_next    = nMemRd;
        wr_next    = nMemWr;
        dsack_next = nDsack;
        gnt_next   = dmaGnt;
        ack_next   = 1'b0;
        sel_next   = ramAddrSel;
        case (state_next)
            IDLE: begin
                // ramAddrSel is left alone so the mux only flips on a new grant
                ce_next    = 4'hF;
                rd_next    = 1'b1;
                wr_next    = 1'b1;
                dsack_next = 2'b11;
                gnt_next   = 1'b0;
            end
            CPU_ACT: begin
                sel_next = 1'b0;
                ce_next  = ~lane_en;
                rd_next  = !RnW;
                wr_next  = RnW;
            end
            CPU_TERM: begin
                dsack_next = 2'b00;
            end
            CPU_END: begin
                wr_next = 1'b1;
            end
            DMA_ACT: begin
                sel_next = 1'b1;
                gnt_next = 1'b1;
                ce_next  = dmaRnW ? 4'h0 : ~dmaBe;
                rd_next  = !dmaRnW;
                wr_next  = dmaRnW;
            end
            DMA_TERM: begin
                ack_next = 1'b1;
                wr_next  = 1'b1;
            end
            DMA_END: begin
                ce_next  = 4'hF;
                rd_next  = 1'b1;
                gnt_next = 1'b0;
            end
            default: begin
                // wait states hold the current outputs
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_bus_arbiter
//  Purpose  : Self-checking bench for ram_bus_arbiter: directed bus cycles
//             followed by randomized CPU/secondary traffic checked against a
//             behavioural model of lanes, latencies and round-robin grants.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_bus_arbiter;

    localparam int WS = 2;

    logic       sysClk = 1'b0;
    logic       sysReset;
    logic       nAS;
    logic       addr31;
    logic [1:0] addrLow;
    logic [1:0] siz;
    logic       RnW;
    logic [1:0] cpuFC;
    logic       dmaReq;
    logic       dmaRnW;
    logic [3:0] dmaBe;
    logic       dmaGnt;
    logic       dmaAck;
    logic       ramAddrSel;
    logic [3:0] nRamCE;
    logic       nMemRd;
    logic       nMemWr;
    logic [1:0] nDsack;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: who was granted last, and where the address mux points
    bit last_dma = 1'b1;
    bit exp_sel  = 1'b0;

    logic [3:0] byte_ce [4] = '{4'h7, 4'hB, 4'hD, 4'hE};

    ram_bus_arbiter #(.WAIT_STATES(WS)) dut (
        .sysClk     (sysClk),
        .sysReset   (sysReset),
        .nAS        (nAS),
        .addr31     (addr31),
        .addrLow    (addrLow),
        .siz        (siz),
        .RnW        (RnW),
        .cpuFC      (cpuFC),
        .dmaReq     (dmaReq),
        .dmaRnW     (dmaRnW),
        .dmaBe      (dmaBe),
        .dmaGnt     (dmaGnt),
        .dmaAck     (dmaAck),
        .ramAddrSel (ramAddrSel),
        .nRamCE     (nRamCE),
        .nMemRd     (nMemRd),
        .nMemWr     (nMemWr),
        .nDsack     (nDsack)
    );

    always #5 sysClk = ~sysClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [10:0] outs();
        return {nRamCE, nMemRd, nMemWr, nDsack, dmaGnt, dmaAck, ramAddrSel};
    endfunction

    function automatic logic [10:0] ev(input logic [3:0] ce, input logic rd, input logic wr,
                                       input logic [1:0] ds, input logic g, input logic a,
                                       input logic s);
        return {ce, rd, wr, ds, g, a, s};
    endfunction

    // Write lanes form one contiguous run starting at A1:A0, clipped at lane 3
    function automatic logic [3:0] model_cpu_ce(input logic [1:0] a, input logic [1:0] s,
                                                input logic rnw);
        int nbytes;
        int first;
        int last;
        logic [3:0] en;
        if (rnw) return 4'h0;
        nbytes = (s == 2'b00) ? 4 : int'(s);
        first  = int'(a);
        last   = first + nbytes - 1;
        if (last > 3) last = 3;
        en = 4'(((1 << (last - first + 1)) - 1) << (3 - last));
        return ~en;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysClk);
        #1;
    endtask

    task automatic start_cpu(input logic [1:0] a, input logic [1:0] s, input logic rnw);
        nAS     = 1'b0;
        addr31  = 1'b0;
        cpuFC   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        addrLow = a;
        siz     = s;
        RnW     = rnw;
    endtask

    task automatic start_dma(input logic [3:0] be, input logic rnw);
        dmaReq = 1'b1;
        dmaBe  = be;
        dmaRnW = rnw;
    endtask

    // Called just after the grant edge of a CPU cycle
    task automatic finish_cpu(input string tag, input logic [3:0] ce, input logic rnw,
                              input int hold);
        int n;
        chk({tag, " grant"}, 16'(outs()), 16'(ev(ce, ~rnw, rnw, 2'b11, 1'b0, 1'b0, 1'b0)));
        n = 0;
        do begin
            step();
            n++;
        end while ((nDsack !== 2'b00) && (n < 16));
        chk({tag, " dsack latency"}, 16'(n), 16'(WS + 1));
        chk({tag, " term"}, 16'(outs()), 16'(ev(ce, ~rnw, rnw, 2'b00, 1'b0, 1'b0, 1'b0)));
        step();
        chk({tag, " end"}, 16'(outs()), 16'(ev(ce, ~rnw, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0)));
        for (int i = 0; i < hold; i++) begin
            step();
            chk({tag, " end hold"}, 16'(outs()), 16'(ev(ce, ~rnw, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0)));
        end
        nAS = 1'b1;
        step();
        chk({tag, " release"}, 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        last_dma = 1'b0;
        exp_sel  = 1'b0;
    endtask

    // Called just after the grant edge of a secondary-master cycle
    task automatic finish_dma(input string tag, input logic [3:0] ce, input logic rnw,
                              input bit keep);
        int n;
        chk({tag, " grant"}, 16'(outs()), 16'(ev(ce, ~rnw, rnw, 2'b11, 1'b1, 1'b0, 1'b1)));
        n = 0;
        do begin
            step();
            n++;
        end while ((dmaAck !== 1'b1) && (n < 16));
        chk({tag, " ack latency"}, 16'(n), 16'(WS + 1));
        chk({tag, " ack"}, 16'(outs()), 16'(ev(ce, ~rnw, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1)));
        if (!keep) dmaReq = 1'b0;
        step();
        chk({tag, " end"}, 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1)));
        step();
        chk({tag, " idle"}, 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1)));
        last_dma = 1'b1;
        exp_sel  = 1'b1;
    endtask

    initial begin
        logic [1:0] ra;
        logic [1:0] rs;
        logic       rr;
        logic       rdr;
        logic [3:0] rbe;
        int         kind;
        bit         w;

        sysReset = 1'b1;
        nAS      = 1'b1;
        addr31   = 1'b0;
        addrLow  = 2'b00;
        siz      = 2'b00;
        RnW      = 1'b1;
        cpuFC    = 2'b01;
        dmaReq   = 1'b0;
        dmaRnW   = 1'b1;
        dmaBe    = 4'hF;

        // Reset values
        repeat (3) step();
        chk("reset outputs", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        sysReset = 1'b0;
        step();
        chk("idle after reset", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));

        // Tie after reset: CPU first, then DMA, then CPU again
        start_cpu(2'b00, 2'b00, 1'b1);
        start_dma(4'hF, 1'b1);
        step();
        finish_cpu("t4 cpu1", 4'h0, 1'b1, 0);
        start_cpu(2'b00, 2'b00, 1'b1);
        step();
        finish_dma("t4 dma", 4'h0, 1'b1, 1'b1);
        step();
        dmaReq = 1'b0;
        finish_cpu("t4 cpu2", 4'h0, 1'b1, 0);

        // CPU long read
        start_cpu(2'b00, 2'b00, 1'b1);
        step();
        finish_cpu("t1 long read", 4'h0, 1'b1, 2);

        // CPU byte writes across all four lanes
        for (int a = 0; a < 4; a++) begin
            start_cpu(2'(a), 2'b01, 1'b0);
            step();
            finish_cpu("t2 byte write", byte_ce[a], 1'b0, 1);
        end

        // Misaligned writes
        start_cpu(2'd2, 2'b00, 1'b0);
        step();
        finish_cpu("t3 long at 2", 4'hC, 1'b0, 0);
        start_cpu(2'd1, 2'b11, 1'b0);
        step();
        finish_cpu("t3 3byte at 1", 4'h8, 1'b0, 0);

        // CPU abort during wait states
        start_cpu(2'd0, 2'b10, 1'b1);
        step();
        chk("t5 grant", 16'(outs()), 16'(ev(4'h0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        step();
        nAS = 1'b1;
        step();
        chk("t5 abort", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        last_dma = 1'b0;
        exp_sel  = 1'b0;
        start_dma(4'b0011, 1'b0);
        step();
        finish_dma("t5 dma after abort", 4'b1100, 1'b0, 1'b0);

        // Reset in the middle of a DMA write
        start_dma(4'h5, 1'b0);
        step();
        chk("t6 grant", 16'(outs()), 16'(ev(4'hA, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1)));
        step();
        sysReset = 1'b1;
        step();
        chk("t6 reset mid dma", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        sysReset = 1'b0;
        dmaReq   = 1'b0;
        last_dma = 1'b1;
        exp_sel  = 1'b0;
        repeat (4) begin
            step();
            chk("t6 no ack", 16'(dmaAck), 16'h0);
        end

        // Non-RAM CPU cycles cause no RAM activity
        nAS    = 1'b0;
        addr31 = 1'b1;
        cpuFC  = 2'b01;
        repeat (3) begin
            step();
            chk("t6 addr31 high", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        end
        addr31 = 1'b0;
        cpuFC  = 2'b11;
        repeat (3) begin
            step();
            chk("t6 fc cpu space", 16'(outs()), 16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0)));
        end
        nAS = 1'b1;
        step();

        // Randomized traffic against the behavioural model
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 3);
            ra   = 2'($urandom);
            rs   = 2'($urandom);
            rr   = 1'($urandom);
            rdr  = 1'($urandom);
            rbe  = 4'($urandom_range(1, 15));
            case (kind)
                0: begin
                    start_cpu(ra, rs, rr);
                    step();
                    finish_cpu("rnd cpu", model_cpu_ce(ra, rs, rr), rr, $urandom_range(0, 2));
                end
                1: begin
                    start_dma(rbe, rdr);
                    step();
                    finish_dma("rnd dma", rdr ? 4'h0 : ~rbe, rdr, 1'b0);
                end
                2: begin
                    start_cpu(ra, rs, rr);
                    start_dma(rbe, rdr);
                    step();
                    w = !last_dma;
                    chk("rnd tie winner", 16'({dmaGnt, ramAddrSel}), 16'({w, w}));
                    if (w) begin
                        nAS = 1'b1;
                        finish_dma("rnd tie dma", rdr ? 4'h0 : ~rbe, rdr, 1'b0);
                    end else begin
                        dmaReq = 1'b0;
                        finish_cpu("rnd tie cpu", model_cpu_ce(ra, rs, rr), rr, 0);
                    end
                end
                default: begin
                    nAS = 1'b0;
                    if ($urandom_range(0, 1) == 1) begin
                        addr31 = 1'b1;
                        cpuFC  = 2'b10;
                    end else begin
                        addr31 = 1'b0;
                        cpuFC  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                    end
                    repeat (2) begin
                        step();
                        chk("rnd non-ram", 16'(outs()),
                            16'(ev(4'hF, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, exp_sel)));
                    end
                    nAS    = 1'b1;
                    addr31 = 1'b0;
                    step();
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
